// File: rtl/ipif_param_regfile.sv
// -----------------------------------------------------------------------------
// ipif_param_regfile
//
// Bus-side register file for the AXI IPIF register protocol. It decodes the
// one-hot read/write chip-enable strobes and applies byte-enabled writes to a
// flat parameter vector that feeds the bus<->IP clock converter. Reads return
// either the stored value or, for read-only registers, the converter's IP
// status slice. Every accepted access produces exactly one registered
// acknowledge cycle.
//
// Ports
//   bus_clk       in   bus clock, all logic on its rising edge
//   bus_rst       in   asynchronous, active-high reset
//   Bus2IP_Data   in   W      write data
//   Bus2IP_BE     in   W/8    write byte enables
//   Bus2IP_RdCE   in   N_REG  read strobe, bit N_REG-1-i selects register i
//   Bus2IP_WrCE   in   N_REG  write strobe, same mapping as Bus2IP_RdCE
//   IP2Bus_Data   out  W      read data, zero outside a read ack
//   IP2Bus_RdAck  out  1      one-cycle read acknowledge
//   IP2Bus_WrAck  out  1      one-cycle write acknowledge
//   IP2Bus_Error  out  1      one-cycle error, coincident with the ack
//   params_out    out  N_REG*W  stored vector (to converter params_from_bus)
//   params_in     in   N_REG*W  status vector (from converter params_to_bus)
// -----------------------------------------------------------------------------
module ipif_param_regfile #(
   parameter int                                      C_S_AXI_DATA_WIDTH = 32,
   parameter int                                      N_REG              = 2,
   parameter logic [N_REG-1:0]                        RO_MASK            = '0,
   parameter logic [N_REG*C_S_AXI_DATA_WIDTH-1:0]     RESET_VALUE        = '0
) (
   input  logic                                   bus_clk,
   input  logic                                   bus_rst,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]          Bus2IP_Data,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        Bus2IP_BE,
   input  logic [N_REG-1:0]                       Bus2IP_RdCE,
   input  logic [N_REG-1:0]                       Bus2IP_WrCE,
   output logic [C_S_AXI_DATA_WIDTH-1:0]          IP2Bus_Data,
   output logic                                   IP2Bus_RdAck,
   output logic                                   IP2Bus_WrAck,
   output logic                                   IP2Bus_Error,
   output logic [N_REG*C_S_AXI_DATA_WIDTH-1:0]    params_out,
   input  logic [N_REG*C_S_AXI_DATA_WIDTH-1:0]    params_in
);

   localparam int W  = C_S_AXI_DATA_WIDTH;
   localparam int NB = W / 8;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACK  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   logic [1:0]         r_state;
   logic [N_REG*W-1:0] r_params;
   logic [W-1:0]       r_data;
   logic               r_rd_ack;
   logic               r_wr_ack;
   logic               r_err;

   logic               w_any_rd;
   logic               w_any_wr;
   logic               w_any;
   logic               w_multi;
   logic               w_sel_ro;
   logic [W-1:0]       w_rd_data;
   logic [N_REG*W-1:0] w_wr_params;
   int                 w_cnt;

   // Decode the strobes: count set bits across both buses, and pick up the
   // selected register's RO flag, read value and byte-merged write value.
   // The merge is only committed when the access turns out to be single-hot.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and infers a latch.
      w_cnt       = 0;
      w_sel_ro    = 1'b0;
      w_rd_data   = '0;
      w_wr_params = r_params;
      for (int i = 0; i < N_REG; i++) begin
         w_cnt = w_cnt + int'(Bus2IP_RdCE[N_REG-1-i]) + int'(Bus2IP_WrCE[N_REG-1-i]);
         if (Bus2IP_RdCE[N_REG-1-i] || Bus2IP_WrCE[N_REG-1-i]) begin
            w_sel_ro  = RO_MASK[i];
            w_rd_data = RO_MASK[i] ? params_in[i*W +: W] : r_params[i*W +: W];
         end
         if (Bus2IP_WrCE[N_REG-1-i]) begin
            for (int b = 0; b < NB; b++) begin
               if (Bus2IP_BE[b]) begin
                  w_wr_params[i*W + b*8 +: 8] = Bus2IP_Data[b*8 +: 8];
               end
            end
         end
      end
      w_any_rd = |Bus2IP_RdCE;
      w_any_wr = |Bus2IP_WrCE;
      w_any    = w_any_rd || w_any_wr;
      w_multi  = (w_cnt > 1);
   end

   // Ack/data/error are pulses: cleared by default every cycle and set only
   // on the edge that accepts an access in IDLE, so they are high for the
   // single ACK cycle. WAIT absorbs strobes held past the ack.
   always_ff @(posedge bus_clk or posedge bus_rst) begin
      if (bus_rst) begin
         // NOTE: the parameter vector is a small register bank, not a RAM,
         // so it is reset alongside the control state.
         r_state  <= S_IDLE;
         r_params <= RESET_VALUE;
         r_data   <= '0;
         r_rd_ack <= 1'b0;
         r_wr_ack <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so the
         // later per-state assignments cleanly override these defaults.
         r_data   <= '0;
         r_rd_ack <= 1'b0;
         r_wr_ack <= 1'b0;
         r_err    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state  <= S_ACK;
                  r_rd_ack <= w_any_rd;
                  r_wr_ack <= w_any_wr;
                  if (w_multi) begin
                     r_err <= 1'b1;
                  end else if (w_any_wr) begin
                     r_err <= w_sel_ro;
                     if (!w_sel_ro) begin
                        r_params <= w_wr_params;
                     end
                  end else begin
                     r_data <= w_rd_data;
                  end
               end
            end
            S_ACK:   r_state <= w_any ? S_WAIT : S_IDLE;
            S_WAIT:  if (!w_any) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign params_out   = r_params;
   assign IP2Bus_Data  = r_data;
   assign IP2Bus_RdAck = r_rd_ack;
   assign IP2Bus_WrAck = r_wr_ack;
   assign IP2Bus_Error = r_err;

endmodule

// File: tb/tb_ipif_param_regfile.sv
// -----------------------------------------------------------------------------
// tb_ipif_param_regfile
//
// Directed bench for ipif_param_regfile with W=32, N_REG=2, register 1
// read-only, RESET_VALUE = {32'h0, 32'hDEAD_BEEF}. Inputs change and outputs
// are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_ipif_param_regfile;

   localparam int          W     = 32;
   localparam int          N_REG = 2;
   localparam logic [1:0]  RO    = 2'b10;
   localparam logic [63:0] RST_V = {32'h0000_0000, 32'hDEAD_BEEF};

   logic          clk;
   logic          rst;
   logic [31:0]   bus_data;
   logic [3:0]    bus_be;
   logic [1:0]    rd_ce;
   logic [1:0]    wr_ce;
   logic [31:0]   ip_data;
   logic          rd_ack;
   logic          wr_ack;
   logic          err;
   logic [63:0]   p_out;
   logic [63:0]   p_in;

   int n_checks   = 0;
   int n_failures = 0;

   ipif_param_regfile #(
      .C_S_AXI_DATA_WIDTH (W),
      .N_REG              (N_REG),
      .RO_MASK            (RO),
      .RESET_VALUE        (RST_V)
   ) dut (
      .bus_clk      (clk),
      .bus_rst      (rst),
      .Bus2IP_Data  (bus_data),
      .Bus2IP_BE    (bus_be),
      .Bus2IP_RdCE  (rd_ce),
      .Bus2IP_WrCE  (wr_ce),
      .IP2Bus_Data  (ip_data),
      .IP2Bus_RdAck (rd_ack),
      .IP2Bus_WrAck (wr_ack),
      .IP2Bus_Error (err),
      .params_out   (p_out),
      .params_in    (p_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst      = 1'b1;
      bus_data = '0;
      bus_be   = '0;
      rd_ce    = '0;
      wr_ce    = '0;
      p_in     = {32'hCAFE_0001, 32'h5555_AAAA};

      // Reset state
      tick();
      tick();
      check("rst_params", p_out, RST_V);
      check("rst_rdack", 64'(rd_ack), 64'h0);
      check("rst_wrack", 64'(wr_ack), 64'h0);
      check("rst_err", 64'(err), 64'h0);
      check("rst_data", 64'(ip_data), 64'h0);
      rst = 1'b0;
      tick();

      // Byte-enabled write to reg 0
      wr_ce    = 2'b10;
      bus_data = 32'h1122_3344;
      bus_be   = 4'b0101;
      tick();
      check("wr0_ack", 64'(wr_ack), 64'h1);
      check("wr0_err", 64'(err), 64'h0);
      check("wr0_rdack", 64'(rd_ack), 64'h0);
      check("wr0_data", 64'(ip_data), 64'h0);
      check("wr0_params", p_out, {32'h0, 32'hDE22_BE44});
      wr_ce = 2'b00;
      tick();
      check("wr0_ack_drop", 64'(wr_ack), 64'h0);

      // Read reg 0 with RdCE held for 4 cycles: one ack, then WAIT
      rd_ce = 2'b10;
      tick();
      check("rd0_ack", 64'(rd_ack), 64'h1);
      check("rd0_data", 64'(ip_data), 64'hDE22_BE44);
      tick();
      check("rd0_hold1_ack", 64'(rd_ack), 64'h0);
      check("rd0_hold1_data", 64'(ip_data), 64'h0);
      tick();
      check("rd0_hold2_ack", 64'(rd_ack), 64'h0);
      tick();
      check("rd0_hold3_ack", 64'(rd_ack), 64'h0);
      rd_ce = 2'b00;
      tick();
      check("rd0_release_ack", 64'(rd_ack), 64'h0);

      // Read of read-only reg 1 returns the status slice
      rd_ce = 2'b01;
      tick();
      check("ro_rd_ack", 64'(rd_ack), 64'h1);
      check("ro_rd_data", 64'(ip_data), 64'hCAFE_0001);
      check("ro_rd_err", 64'(err), 64'h0);
      rd_ce = 2'b00;
      tick();

      // Write to read-only reg 1: error ack, no update
      wr_ce    = 2'b01;
      bus_data = 32'hFFFF_FFFF;
      bus_be   = 4'b1111;
      tick();
      check("ro_wr_ack", 64'(wr_ack), 64'h1);
      check("ro_wr_err", 64'(err), 64'h1);
      check("ro_wr_params", p_out, {32'h0, 32'hDE22_BE44});
      wr_ce = 2'b00;
      tick();
      check("ro_wr_err_drop", 64'(err), 64'h0);

      // Multi-hot strobes: both acks + error, no data, no change
      rd_ce    = 2'b01;
      wr_ce    = 2'b10;
      bus_data = 32'hAAAA_AAAA;
      tick();
      check("mh_rdack", 64'(rd_ack), 64'h1);
      check("mh_wrack", 64'(wr_ack), 64'h1);
      check("mh_err", 64'(err), 64'h1);
      check("mh_data", 64'(ip_data), 64'h0);
      check("mh_params", p_out, {32'h0, 32'hDE22_BE44});
      rd_ce = 2'b00;
      wr_ce = 2'b00;
      tick();

      // Back-to-back write then read of the same register
      wr_ce    = 2'b10;
      bus_data = 32'h7700_0000;
      bus_be   = 4'b1000;
      tick();
      check("b2b_wrack", 64'(wr_ack), 64'h1);
      wr_ce = 2'b00;
      tick();
      rd_ce = 2'b10;
      tick();
      check("b2b_rdack", 64'(rd_ack), 64'h1);
      check("b2b_data", 64'(ip_data), 64'h7722_BE44);
      rd_ce = 2'b00;
      tick();

      // Reset asserted during the ACK cycle
      wr_ce    = 2'b10;
      bus_data = 32'h0000_0000;
      bus_be   = 4'b1111;
      tick();
      check("rack_wrack", 64'(wr_ack), 64'h1);
      check("rack_params_pre", p_out, 64'h0);
      rst = 1'b1;
      #1;
      check("rack_ack_clr", 64'(wr_ack), 64'h0);
      check("rack_params", p_out, RST_V);
      wr_ce = 2'b00;
      tick();
      // Strobe asserted in the same cycle reset is released
      rst   = 1'b0;
      rd_ce = 2'b10;
      tick();
      check("post_rst_rdack", 64'(rd_ack), 64'h1);
      check("post_rst_data", 64'(ip_data), 64'hDEAD_BEEF);
      rd_ce = 2'b00;
      tick();
      check("post_rst_idle", 64'(rd_ack), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
      $finish;
   end

endmodule
